plab5_mcore_mem_req_tracker: RTL and testbench

//  Requester-side end of the secure memory path: sits between a core/cache port and the request/response network

---
 rtl/plab5_mcore_mem_req_tracker.sv | 225 ++++++++++++++++++++++
 tb/tb_plab5_mcore_mem_req_tracker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plab5_mcore_mem_req_tracker.sv
// Requester-side tracker for the secure memory path: tags requests, records in-flight
// {opaque,type,sec} in order, filters responses against the head and retires denied requests by timeout.

module plab5_mcore_mem_req_tracker_fifo #(
    parameter int p_width = 12,
    parameter int p_depth = 4,
    localparam int PW = $clog2(p_depth),
    localparam int CW = PW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [p_width-1:0] push_entry,
    input  logic               pop,
    output logic [p_width-1:0] head,
    output logic [CW-1:0]      count
);

    logic [p_width-1:0] mem [p_depth];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

module plab5_mcore_mem_req_tracker #(
    parameter int p_opaque_nbits    = 8,
    parameter int p_addr_nbits      = 32,
    parameter int p_data_nbits      = 32,
    parameter int p_max_outstanding = 4,
    parameter int p_timeout         = 64,
    localparam int req_cnbits  = 3 + p_opaque_nbits + p_addr_nbits + 2,
    localparam int resp_cnbits = 3 + p_opaque_nbits + 2,
    localparam int CW          = $clog2(p_max_outstanding) + 1
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    core_req_sec_level,
    input  logic [req_cnbits-1:0]   core_req_control,
    input  logic [p_data_nbits-1:0] core_req_data,
    input  logic                    core_req_val,
    output logic                    core_req_rdy,

    output logic                    net_req_sec_level,
    output logic [req_cnbits-1:0]   net_req_control,
    output logic [p_data_nbits-1:0] net_req_data,
    output logic                    net_req_val,
    input  logic                    net_req_rdy,

    input  logic                    net_resp_sec_level,
    input  logic [resp_cnbits-1:0]  net_resp_control,
    input  logic [p_data_nbits-1:0] net_resp_data,
    input  logic                    net_resp_val,
    output logic                    net_resp_rdy,

    output logic [resp_cnbits-1:0]  core_resp_control,
    output logic [p_data_nbits-1:0] core_resp_data,
    output logic                    core_resp_val,
    input  logic                    core_resp_rdy,

    output logic [CW-1:0]           outstanding,
    output logic                    err_val,
    output logic [1:0]              err_code
);

    localparam int TW = $clog2(p_timeout) + 1;

    typedef struct packed {
        logic [p_opaque_nbits-1:0] opaque;
        logic [2:0]                typ;
        logic                      sec;
    } entry_t;

    typedef enum logic {PASS, SYNTH} state_t;

    localparam logic [1:0] ERR_OPAQUE  = 2'b01;
    localparam logic [1:0] ERR_SEC     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    state_t                    state, state_nxt;
    entry_t                    push_e, head_e;
    logic [$bits(entry_t)-1:0] head_bits;
    logic [CW-1:0]             count;
    logic [TW-1:0]             timer;
    logic                      full, empty, push, pop;
    logic                      err_set;
    logic [1:0]                err_code_nxt;

    logic [2:0]                req_type, resp_type;
    logic [p_opaque_nbits-1:0] req_opaque, resp_opaque;

    assign req_type    = core_req_control[req_cnbits-1 -: 3];
    assign req_opaque  = core_req_control[req_cnbits-4 -: p_opaque_nbits];
    assign resp_type   = net_resp_control[resp_cnbits-1 -: 3];
    assign resp_opaque = net_resp_control[resp_cnbits-4 -: p_opaque_nbits];

    assign full  = (count == CW'(p_max_outstanding));
    assign empty = (count == '0);

    // Request path is pure wiring; only the handshake is gated by capacity and reset.
    assign net_req_sec_level = core_req_sec_level;
    assign net_req_control   = core_req_control;
    assign net_req_data      = core_req_data;
    assign net_req_val       = reset & core_req_val & !full;
    assign core_req_rdy      = reset & net_req_rdy & !full;
    assign push              = net_req_val & net_req_rdy;

    assign push_e = '{opaque: req_opaque, typ: req_type, sec: core_req_sec_level};
    assign head_e = head_bits;

    plab5_mcore_mem_req_tracker_fifo #(
        .p_width (($bits(entry_t))),
        .p_depth (p_max_outstanding)
    ) tracker (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_e),
        .pop        (pop),
        .head       (head_bits),
        .count      (count)
    );

    assign outstanding = count;

    always_comb begin
        state_nxt         = state;
        net_resp_rdy      = 1'b0;
        core_resp_val     = 1'b0;
        core_resp_control = net_resp_control;
        core_resp_data    = net_resp_data;
        pop               = 1'b0;
        err_set           = 1'b0;
        err_code_nxt      = ERR_OPAQUE;
        if (reset) begin
            case (state)
                PASS: begin
                    if (net_resp_val) begin
                        if (empty || resp_opaque != head_e.opaque) begin
                            net_resp_rdy = 1'b1;
                            err_set      = 1'b1;
                            err_code_nxt = ERR_OPAQUE;
                        end else if (net_resp_sec_level != head_e.sec) begin
                            net_resp_rdy = 1'b1;
                            err_set      = 1'b1;
                            err_code_nxt = ERR_SEC;
                        end else begin
                            core_resp_val = 1'b1;
                            net_resp_rdy  = core_resp_rdy;
                            pop           = core_resp_rdy;
                        end
                    end
                    if (!empty && !pop && timer == TW'(p_timeout - 1))
                        state_nxt = SYNTH;
                end
                SYNTH: begin
                    // Gate denied the head silently: hand the core a zero-data stand-in.
                    core_resp_val     = 1'b1;
                    core_resp_control = {head_e.typ, head_e.opaque, 2'b00};
                    core_resp_data    = '0;
                    if (core_resp_rdy) begin
                        pop          = 1'b1;
                        err_set      = 1'b1;
                        err_code_nxt = ERR_TIMEOUT;
                        state_nxt    = PASS;
                    end
                end
                default: state_nxt = PASS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= PASS;
        else
            state <= state_nxt;
    end

    // Counts cycles the current head has waited; saturates so it cannot wrap back to the trigger value.
    always_ff @(posedge clk) begin
        if (!reset || pop || empty)
            timer <= '0;
        else if (timer != '1)
            timer <= timer + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_val  <= 1'b0;
            err_code <= 2'b00;
        end else begin
            err_val <= err_set;
            if (err_set)
                err_code <= err_code_nxt;
        end
    end

endmodule

// File: tb/tb_plab5_mcore_mem_req_tracker.sv
// Directed bench for plab5_mcore_mem_req_tracker: pass-through, full, sec mismatch, timeout, unexpected, reset.

module tb_plab5_mcore_mem_req_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req_sec_level;
    logic [44:0] core_req_control;
    logic [31:0] core_req_data;
    logic        core_req_val, core_req_rdy;
    logic        net_req_sec_level;
    logic [44:0] net_req_control;
    logic [31:0] net_req_data;
    logic        net_req_val, net_req_rdy;
    logic        net_resp_sec_level;
    logic [12:0] net_resp_control;
    logic [31:0] net_resp_data;
    logic        net_resp_val, net_resp_rdy;
    logic [12:0] core_resp_control;
    logic [31:0] core_resp_data;
    logic        core_resp_val, core_resp_rdy;
    logic [2:0]  outstanding;
    logic        err_val;
    logic [1:0]  err_code;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    plab5_mcore_mem_req_tracker dut (
        .clk(clk), .reset(reset),
        .core_req_sec_level(core_req_sec_level), .core_req_control(core_req_control),
        .core_req_data(core_req_data), .core_req_val(core_req_val), .core_req_rdy(core_req_rdy),
        .net_req_sec_level(net_req_sec_level), .net_req_control(net_req_control),
        .net_req_data(net_req_data), .net_req_val(net_req_val), .net_req_rdy(net_req_rdy),
        .net_resp_sec_level(net_resp_sec_level), .net_resp_control(net_resp_control),
        .net_resp_data(net_resp_data), .net_resp_val(net_resp_val), .net_resp_rdy(net_resp_rdy),
        .core_resp_control(core_resp_control), .core_resp_data(core_resp_data),
        .core_resp_val(core_resp_val), .core_resp_rdy(core_resp_rdy),
        .outstanding(outstanding), .err_val(err_val), .err_code(err_code)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [44:0] req_ctl(input logic [7:0] op);
        return {3'd0, op, 32'h0000_1000, 2'd0};
    endfunction

    function automatic logic [12:0] resp_ctl(input logic [7:0] op);
        return {3'd0, op, 2'd0};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input logic v, input logic [7:0] op, input logic sec);
        core_req_val       = v;
        core_req_control   = req_ctl(op);
        core_req_sec_level = sec;
        core_req_data      = {24'h0, op};
    endtask

    task automatic set_resp(input logic v, input logic [7:0] op, input logic sec, input logic [31:0] d);
        net_resp_val       = v;
        net_resp_control   = resp_ctl(op);
        net_resp_sec_level = sec;
        net_resp_data      = d;
    endtask

    initial begin
        reset = 1'b0;
        net_req_rdy   = 1'b1;
        core_resp_rdy = 1'b1;
        set_req(1'b1, 8'h00, 1'b0);
        set_resp(1'b1, 8'h00, 1'b0, 32'h0);
        tick(); tick();
        #1;
        chk("rst_core_req_rdy", core_req_rdy, 0);
        chk("rst_net_req_val", net_req_val, 0);
        chk("rst_net_resp_rdy", net_resp_rdy, 0);
        chk("rst_core_resp_val", core_resp_val, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err_val", err_val, 0);
        chk("rst_err_code", err_code, 0);
        set_req(1'b0, 8'h00, 1'b0);
        set_resp(1'b0, 8'h00, 1'b0, 32'h0);
        reset = 1'b1;
        tick();

        // T1 pass-through
        set_req(1'b1, 8'h05, 1'b0);
        #1;
        chk("t1_net_req_val", net_req_val, 1);
        chk("t1_core_req_rdy", core_req_rdy, 1);
        chk("t1_net_req_ctl", net_req_control, req_ctl(8'h05));
        tick();
        set_req(1'b0, 8'h00, 1'b0);
        chk("t1_outstanding_1", outstanding, 1);
        set_resp(1'b1, 8'h05, 1'b0, 32'h0000_CAFE);
        #1;
        chk("t1_core_resp_val", core_resp_val, 1);
        chk("t1_core_resp_data", core_resp_data, 32'h0000_CAFE);
        chk("t1_net_resp_rdy", net_resp_rdy, 1);
        tick();
        set_resp(1'b0, 8'h00, 1'b0, 32'h0);
        chk("t1_outstanding_0", outstanding, 0);
        chk("t1_no_err", err_val, 0);

        // T2 full, wrap, simultaneous push/pop, opaque mismatch
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 8'h40 + 8'(i), 1'b0);
            tick();
        end
        chk("t2_outstanding_4", outstanding, 4);
        set_req(1'b1, 8'h44, 1'b0);
        set_resp(1'b1, 8'h40, 1'b0, 32'h40);
        #1;
        chk("t2_full_core_req_rdy", core_req_rdy, 0);
        chk("t2_full_net_req_val", net_req_val, 0);
        chk("t2_head_resp_val", core_resp_val, 1);
        tick();
        set_resp(1'b0, 8'h00, 1'b0, 32'h0);
        chk("t2_outstanding_3", outstanding, 3);
        #1;
        chk("t2_5th_core_req_rdy", core_req_rdy, 1);
        tick();
        set_req(1'b0, 8'h00, 1'b0);
        chk("t2_outstanding_4b", outstanding, 4);
        set_resp(1'b1, 8'h41, 1'b0, 32'h41);
        tick();
        chk("t2_outstanding_after41", outstanding, 3);
        set_req(1'b1, 8'h45, 1'b0);
        set_resp(1'b1, 8'h42, 1'b0, 32'h42);
        #1;
        chk("t2_resp42_data", core_resp_data, 32'h42);
        tick();
        set_req(1'b0, 8'h00, 1'b0);
        chk("t2_pushpop_outstanding", outstanding, 3);
        set_resp(1'b1, 8'h99, 1'b0, 32'h99);
        #1;
        chk("t2_mism_net_resp_rdy", net_resp_rdy, 1);
        chk("t2_mism_core_resp_val", core_resp_val, 0);
        tick();
        set_resp(1'b0, 8'h00, 1'b0, 32'h0);
        chk("t2_mism_err_val", err_val, 1);
        chk("t2_mism_err_code", err_code, 2'b01);
        chk("t2_mism_outstanding", outstanding, 3);
        for (int i = 0; i < 3; i++) begin
            set_resp(1'b1, 8'h43 + 8'(i), 1'b0, 32'h43 + 32'(i));
            #1;
            chk("t2_drain_data", core_resp_data, 32'h43 + 32'(i));
            tick();
        end
        set_resp(1'b0, 8'h00, 1'b0, 32'h0);
        chk("t2_drained", outstanding, 0);
        chk("t2_err_cleared", err_val, 0);

        // T3 sec mismatch
        set_req(1'b1, 8'h11, 1'b1);
        tick();
        set_req(1'b0, 8'h00, 1'b0);
        set_resp(1'b1, 8'h11, 1'b0, 32'h11);
        #1;
        chk("t3_core_resp_val", core_resp_val, 0);
        chk("t3_net_resp_rdy", net_resp_rdy, 1);
        tick();
        set_resp(1'b0, 8'h00, 1'b0, 32'h0);
        chk("t3_err_val", err_val, 1);
        chk("t3_err_code", err_code, 2'b10);
        chk("t3_outstanding", outstanding, 1);
        tick();
        chk("t3_err_pulse", err_val, 0);
        chk("t3_err_code_held", err_code, 2'b10);
        set_resp(1'b1, 8'h11, 1'b1, 32'h1111);
        #1;
        chk("t3_retire_val", core_resp_val, 1);
        tick();
        set_resp(1'b0, 8'h00, 1'b0, 32'h0);
        chk("t3_outstanding_0", outstanding, 0);

        // T4 timeout
        core_resp_rdy = 1'b0;
        set_req(1'b1, 8'h22, 1'b0);
        tick();
        set_req(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 63; i++) tick();
        chk("t4_not_yet", core_resp_val, 0);
        tick();
        chk("t4_synth_val", core_resp_val, 1);
        chk("t4_synth_ctl", core_resp_control, resp_ctl(8'h22));
        chk("t4_synth_data", core_resp_data, 0);
        chk("t4_synth_net_resp_rdy", net_resp_rdy, 0);
        core_resp_rdy = 1'b1;
        tick();
        chk("t4_err_val", err_val, 1);
        chk("t4_err_code", err_code, 2'b11);
        chk("t4_outstanding", outstanding, 0);
        chk("t4_back_to_pass", core_resp_val, 0);
        set_resp(1'b1, 8'h22, 1'b0, 32'h22);
        #1;
        chk("t4_late_rdy", net_resp_rdy, 1);
        chk("t4_late_core_val", core_resp_val, 0);
        tick();
        set_resp(1'b0, 8'h00, 1'b0, 32'h0);
        chk("t4_late_err_code", err_code, 2'b01);

        // T5 unexpected on empty
        tick();
        set_resp(1'b1, 8'h33, 1'b0, 32'h33);
        #1;
        chk("t5_net_resp_rdy", net_resp_rdy, 1);
        chk("t5_core_resp_val", core_resp_val, 0);
        tick();
        set_resp(1'b0, 8'h00, 1'b0, 32'h0);
        chk("t5_err_val", err_val, 1);
        chk("t5_err_code", err_code, 2'b01);

        // T6 reset with 3 outstanding
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 8'h60 + 8'(i), 1'b0);
            tick();
        end
        chk("t6_outstanding_3", outstanding, 3);
        reset = 1'b0;
        set_req(1'b1, 8'h63, 1'b0);
        set_resp(1'b1, 8'h60, 1'b0, 32'h60);
        #1;
        chk("t6_core_req_rdy", core_req_rdy, 0);
        chk("t6_net_req_val", net_req_val, 0);
        chk("t6_net_resp_rdy", net_resp_rdy, 0);
        chk("t6_core_resp_val", core_resp_val, 0);
        tick();
        chk("t6_outstanding_0", outstanding, 0);
        chk("t6_err_val", err_val, 0);
        chk("t6_err_code", err_code, 0);
        reset = 1'b1;
        set_req(1'b0, 8'h00, 1'b0);
        #1;
        chk("t6_late_rdy", net_resp_rdy, 1);
        chk("t6_late_core_val", core_resp_val, 0);
        tick();
        set_resp(1'b0, 8'h00, 1'b0, 32'h0);
        chk("t6_late_err_val", err_val, 1);
        chk("t6_late_err_code", err_code, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
